// File: rtl/sid_port_arbiter_if.sv
// rtl/sid_port_arbiter_if.sv - host, local and resource buses of the SID/DIP port arbiter
interface sid_port_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          host_req;
    logic          host_read;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_dtack;
    logic [DW-1:0] host_rdata;

    logic          loc_req;
    logic          loc_read;
    logic [AW-1:0] loc_addr;
    logic [DW-1:0] loc_wdata;
    logic          loc_ack;
    logic [DW-1:0] loc_rdata;

    logic          res_cs;
    logic          res_we;
    logic [AW-1:0] res_addr;
    logic [DW-1:0] res_wdata;
    logic [DW-1:0] res_rdata;

    modport slave (
        input  host_req, host_read, host_addr, host_wdata,
        output host_dtack, host_rdata,
        input  loc_req, loc_read, loc_addr, loc_wdata,
        output loc_ack, loc_rdata,
        output res_cs, res_we, res_addr, res_wdata,
        input  res_rdata
    );

    modport master (
        output host_req, host_read, host_addr, host_wdata,
        input  host_dtack, host_rdata,
        output loc_req, loc_read, loc_addr, loc_wdata,
        input  loc_ack, loc_rdata,
        input  res_cs, res_we, res_addr, res_wdata,
        output res_rdata
    );
endinterface

// File: rtl/sid_port_arbiter.sv
// rtl/sid_port_arbiter.sv - round-robin arbiter sharing the SID register port between host and local sequencer
module sid_port_arbiter #(
    parameter int AW          = 4,
    parameter int DW          = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    sid_port_arbiter_if.slave     bus,
    output logic                  busy
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        HOST_HOLD = 2'd2,
        LOC_ACK   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic       host_req_q;
    logic       loc_req_q;
    logic       owner_host;
    logic       last_host;
    logic       op_read;
    logic [3:0] cnt;
    logic       host_valid;
    logic       loc_valid;
    logic       grant_host;
    logic       grant_loc;

    // A request must be seen both in the sampling register and live to win a grant.
    assign host_valid = host_req_q & bus.host_req;
    assign loc_valid  = loc_req_q & bus.loc_req;
    assign grant_host = host_valid & (~loc_valid | ~last_host);
    assign grant_loc  = loc_valid & (~host_valid | last_host);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_host || grant_loc) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_next = owner_host ? HOST_HOLD : LOC_ACK;
                end
            end
            HOST_HOLD: begin
                if (bus.host_dtack && !bus.host_req) begin
                    state_next = IDLE;
                end
            end
            LOC_ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            host_req_q     <= 1'b0;
            loc_req_q      <= 1'b0;
            owner_host     <= 1'b0;
            last_host      <= 1'b0;
            op_read        <= 1'b0;
            cnt            <= 4'd0;
            bus.res_cs     <= 1'b0;
            bus.res_we     <= 1'b0;
            bus.res_addr   <= '0;
            bus.res_wdata  <= '0;
            bus.host_dtack <= 1'b0;
            bus.host_rdata <= {DW{1'b1}};
            bus.loc_ack    <= 1'b0;
            bus.loc_rdata  <= {DW{1'b1}};
        end else begin
            host_req_q  <= bus.host_req;
            loc_req_q   <= bus.loc_req;
            bus.loc_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_host || grant_loc) begin
                        owner_host    <= grant_host;
                        last_host     <= grant_host;
                        op_read       <= grant_host ? bus.host_read : bus.loc_read;
                        bus.res_addr  <= grant_host ? bus.host_addr : bus.loc_addr;
                        bus.res_wdata <= grant_host ? bus.host_wdata : bus.loc_wdata;
                        bus.res_cs    <= 1'b1;
                        bus.res_we    <= grant_host ? ~bus.host_read : ~bus.loc_read;
                        cnt           <= WAIT_LOAD;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        bus.res_cs <= 1'b0;
                        bus.res_we <= 1'b0;
                        if (op_read && owner_host) begin
                            bus.host_rdata <= bus.res_rdata;
                        end
                        if (op_read && !owner_host) begin
                            bus.loc_rdata <= bus.res_rdata;
                        end
                        if (!owner_host) begin
                            bus.loc_ack <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOST_HOLD: begin
                    // First hold cycle raises DTACK unconditionally so a host that
                    // already dropped its request still sees a one-cycle pulse.
                    if (!bus.host_dtack) begin
                        bus.host_dtack <= 1'b1;
                    end else if (!bus.host_req) begin
                        bus.host_dtack <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sid_port_arbiter.sv
// tb/tb_sid_port_arbiter.sv - directed self-checking bench for sid_port_arbiter
module tb_sid_port_arbiter;
    logic CLK = 1'b0;
    logic RESET;
    logic busy;
    int   total = 0;
    int   bad = 0;

    logic [7:0] mem [16];
    logic       prev_cs = 1'b0;
    logic [3:0] glog [$];

    always #5 CLK = ~CLK;

    sid_port_arbiter_if #(.AW(4), .DW(8)) bus ();

    sid_port_arbiter #(.AW(4), .DW(8), .WAIT_CYCLES(2)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave),
        .busy  (busy)
    );

    // Register-file model: fixed contents on reset, writes land on res_cs&&res_we.
    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
            mem[3] <= 8'hA5;
            mem[4] <= 8'hC3;
            mem[5] <= 8'h11;
            mem[6] <= 8'h22;
        end else if (bus.res_cs && bus.res_we) begin
            mem[bus.res_addr] <= bus.res_wdata;
        end
    end
    assign bus.res_rdata = mem[bus.res_addr];

    always @(posedge CLK) prev_cs <= bus.res_cs;
    always @(negedge CLK) if (bus.res_cs && !prev_cs) glog.push_back(bus.res_addr);

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RESET = 1'b1;
        bus.host_req = 1'b0;
        bus.loc_req = 1'b0;
        tick;
        tick;
        RESET = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        tick;
        tick;
        total++; if (bus.res_cs !== 1'b0) begin bad++; $display("FAIL rst_cs got=%b exp=0", bus.res_cs); end
        total++; if (bus.res_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", bus.res_we); end
        total++; if (bus.host_dtack !== 1'b0) begin bad++; $display("FAIL rst_dtack got=%b exp=0", bus.host_dtack); end
        total++; if (bus.loc_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", bus.loc_ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (bus.res_addr !== 4'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.res_addr); end
        total++; if (bus.res_wdata !== 8'h00) begin bad++; $display("FAIL rst_wdata got=%h exp=00", bus.res_wdata); end
        total++; if (bus.host_rdata !== 8'hFF) begin bad++; $display("FAIL rst_hrdata got=%h exp=ff", bus.host_rdata); end
        total++; if (bus.loc_rdata !== 8'hFF) begin bad++; $display("FAIL rst_lrdata got=%h exp=ff", bus.loc_rdata); end
        RESET = 1'b0;
        tick;
    endtask

    task automatic test_host_read;
        bus.host_read = 1'b1; bus.host_addr = 4'd3; bus.host_wdata = 8'h00; bus.host_req = 1'b1;
        tick;
        total++; if (bus.res_cs !== 1'b0) begin bad++; $display("FAIL hr_cs_sample got=%b exp=0", bus.res_cs); end
        tick;
        total++; if (bus.res_cs !== 1'b1) begin bad++; $display("FAIL hr_cs_grant got=%b exp=1", bus.res_cs); end
        total++; if (bus.res_we !== 1'b0) begin bad++; $display("FAIL hr_we got=%b exp=0", bus.res_we); end
        total++; if (bus.res_addr !== 4'd3) begin bad++; $display("FAIL hr_addr got=%h exp=3", bus.res_addr); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL hr_busy got=%b exp=1", busy); end
        tick;
        total++; if (bus.res_cs !== 1'b1) begin bad++; $display("FAIL hr_cs_2nd got=%b exp=1", bus.res_cs); end
        tick;
        total++; if (bus.res_cs !== 1'b0) begin bad++; $display("FAIL hr_cs_end got=%b exp=0", bus.res_cs); end
        total++; if (bus.host_dtack !== 1'b0) begin bad++; $display("FAIL hr_dtack_early got=%b exp=0", bus.host_dtack); end
        tick;
        total++; if (bus.host_dtack !== 1'b1) begin bad++; $display("FAIL hr_dtack_rise got=%b exp=1", bus.host_dtack); end
        total++; if (bus.host_rdata !== 8'hA5) begin bad++; $display("FAIL hr_rdata got=%h exp=a5", bus.host_rdata); end
        tick;
        total++; if (bus.host_dtack !== 1'b1) begin bad++; $display("FAIL hr_dtack_held got=%b exp=1", bus.host_dtack); end
        bus.host_req = 1'b0;
        tick;
        total++; if (bus.host_dtack !== 1'b0) begin bad++; $display("FAIL hr_dtack_fall got=%b exp=0", bus.host_dtack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hr_idle got=%b exp=0", busy); end
        tick;
    endtask

    task automatic test_local_write;
        bus.loc_read = 1'b0; bus.loc_addr = 4'd1; bus.loc_wdata = 8'h3C; bus.loc_req = 1'b1;
        tick;
        tick;
        total++; if (bus.res_cs !== 1'b1 || bus.res_we !== 1'b1) begin bad++; $display("FAIL lw_cs_we got=%b%b exp=11", bus.res_cs, bus.res_we); end
        total++; if (bus.res_addr !== 4'd1) begin bad++; $display("FAIL lw_addr got=%h exp=1", bus.res_addr); end
        total++; if (bus.res_wdata !== 8'h3C) begin bad++; $display("FAIL lw_wdata got=%h exp=3c", bus.res_wdata); end
        tick;
        total++; if (bus.res_cs !== 1'b1 || bus.res_we !== 1'b1) begin bad++; $display("FAIL lw_cs_we2 got=%b%b exp=11", bus.res_cs, bus.res_we); end
        tick;
        total++; if (bus.res_cs !== 1'b0 || bus.res_we !== 1'b0) begin bad++; $display("FAIL lw_cs_we_end got=%b%b exp=00", bus.res_cs, bus.res_we); end
        total++; if (bus.loc_ack !== 1'b1) begin bad++; $display("FAIL lw_ack got=%b exp=1", bus.loc_ack); end
        total++; if (bus.loc_rdata !== 8'hFF) begin bad++; $display("FAIL lw_rdata got=%h exp=ff", bus.loc_rdata); end
        bus.loc_req = 1'b0;
        tick;
        total++; if (bus.loc_ack !== 1'b0) begin bad++; $display("FAIL lw_ack_pulse got=%b exp=0", bus.loc_ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL lw_idle got=%b exp=0", busy); end
        total++; if (mem[1] !== 8'h3C) begin bad++; $display("FAIL lw_mem got=%h exp=3c", mem[1]); end
    endtask

    task automatic test_drop_before_grant;
        bus.loc_read = 1'b1; bus.loc_addr = 4'd6; bus.loc_req = 1'b1;
        tick;
        bus.loc_req = 1'b0;
        tick;
        total++; if (bus.res_cs !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL drop_nogrant got=%b%b exp=00", bus.res_cs, busy); end
        tick;
        total++; if (bus.res_cs !== 1'b0) begin bad++; $display("FAIL drop_nogrant2 got=%b exp=0", bus.res_cs); end
    endtask

    task automatic test_round_robin;
        int base;
        int hcnt;
        int lcnt;
        int cyc;
        logic [3:0] exp_addr [4];
        exp_addr[0] = 4'd5; exp_addr[1] = 4'd6; exp_addr[2] = 4'd5; exp_addr[3] = 4'd6;
        do_reset;
        base = glog.size();
        hcnt = 0; lcnt = 0; cyc = 0;
        bus.host_read = 1'b1; bus.host_addr = 4'd5;
        bus.loc_read = 1'b1; bus.loc_addr = 4'd6;
        bus.host_req = 1'b1; bus.loc_req = 1'b1;
        while (cyc < 300 && !(hcnt == 2 && lcnt == 2 && !busy)) begin
            tick;
            cyc++;
            if (bus.host_req && bus.host_dtack) begin
                total++; if (bus.host_rdata !== 8'h11) begin bad++; $display("FAIL rr_hrdata got=%h exp=11", bus.host_rdata); end
                bus.host_req = 1'b0;
                hcnt++;
            end else if (!bus.host_req && !bus.host_dtack && hcnt < 2) begin
                bus.host_req = 1'b1;
            end
            if (bus.loc_ack) begin
                total++; if (bus.loc_rdata !== 8'h22) begin bad++; $display("FAIL rr_lrdata got=%h exp=22", bus.loc_rdata); end
                bus.loc_req = 1'b0;
                lcnt++;
            end else if (!bus.loc_req && lcnt < 2) begin
                bus.loc_req = 1'b1;
            end
        end
        total++; if (cyc >= 300) begin bad++; $display("FAIL rr_timeout got=%0d exp<300", cyc); end
        total++; if (glog.size() - base !== 4) begin bad++; $display("FAIL rr_count got=%0d exp=4", glog.size() - base); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (base + i >= glog.size()) begin
                bad++; $display("FAIL rr_order[%0d] got=none exp=%0d", i, exp_addr[i]);
            end else if (glog[base + i] !== exp_addr[i]) begin
                bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, glog[base + i], exp_addr[i]);
            end
        end
        tick;
    endtask

    task automatic test_hold_blocks_local;
        int n;
        bus.host_read = 1'b1; bus.host_addr = 4'd3; bus.host_req = 1'b1;
        n = 0;
        while (bus.host_dtack !== 1'b1 && n < 20) begin tick; n++; end
        total++; if (bus.host_dtack !== 1'b1) begin bad++; $display("FAIL hb_dtack_timeout got=%b exp=1", bus.host_dtack); end
        bus.loc_read = 1'b0; bus.loc_addr = 4'd2; bus.loc_wdata = 8'h5A; bus.loc_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            total++; if (bus.res_cs !== 1'b0) begin bad++; $display("FAIL hb_blocked[%0d] got=%b exp=0", i, bus.res_cs); end
        end
        bus.host_req = 1'b0;
        n = 0;
        while (bus.res_cs !== 1'b1 && n < 20) begin tick; n++; end
        total++; if (bus.res_cs !== 1'b1) begin bad++; $display("FAIL hb_cs_timeout got=%b exp=1", bus.res_cs); end
        total++; if (bus.res_addr !== 4'd2 || bus.res_we !== 1'b1) begin bad++; $display("FAIL hb_local got=%h/%b exp=2/1", bus.res_addr, bus.res_we); end
        n = 0;
        while (bus.loc_ack !== 1'b1 && n < 20) begin tick; n++; end
        total++; if (bus.loc_ack !== 1'b1) begin bad++; $display("FAIL hb_ack_timeout got=%b exp=1", bus.loc_ack); end
        bus.loc_req = 1'b0;
        tick;
        total++; if (mem[2] !== 8'h5A) begin bad++; $display("FAIL hb_mem got=%h exp=5a", mem[2]); end
    endtask

    task automatic test_reset_mid_access;
        int n;
        bus.host_read = 1'b1; bus.host_addr = 4'd3; bus.host_req = 1'b1;
        tick;
        tick;
        total++; if (bus.res_cs !== 1'b1) begin bad++; $display("FAIL rm_cs got=%b exp=1", bus.res_cs); end
        RESET = 1'b1;
        bus.host_req = 1'b0;
        tick;
        total++; if (bus.res_cs !== 1'b0 || bus.host_dtack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_outs got=%b%b%b exp=000", bus.res_cs, bus.host_dtack, busy); end
        total++; if (bus.host_rdata !== 8'hFF) begin bad++; $display("FAIL rm_hrdata got=%h exp=ff", bus.host_rdata); end
        total++; if (bus.loc_rdata !== 8'hFF) begin bad++; $display("FAIL rm_lrdata got=%h exp=ff", bus.loc_rdata); end
        RESET = 1'b0;
        tick;
        bus.host_req = 1'b1;
        n = 0;
        while (bus.host_dtack !== 1'b1 && n < 20) begin tick; n++; end
        total++; if (bus.host_dtack !== 1'b1) begin bad++; $display("FAIL rm_dtack_timeout got=%b exp=1", bus.host_dtack); end
        total++; if (bus.host_rdata !== 8'hA5) begin bad++; $display("FAIL rm_rdata got=%h exp=a5", bus.host_rdata); end
        bus.host_req = 1'b0;
        tick;
        total++; if (bus.host_dtack !== 1'b0) begin bad++; $display("FAIL rm_dtack_fall got=%b exp=0", bus.host_dtack); end
        tick;
    endtask

    task automatic test_host_drop;
        bus.host_read = 1'b1; bus.host_addr = 4'd4; bus.host_req = 1'b1;
        tick;
        tick;
        total++; if (bus.res_cs !== 1'b1) begin bad++; $display("FAIL hd_cs got=%b exp=1", bus.res_cs); end
        bus.host_req = 1'b0;
        tick;
        total++; if (bus.res_cs !== 1'b1) begin bad++; $display("FAIL hd_cs_kept got=%b exp=1", bus.res_cs); end
        tick;
        total++; if (bus.res_cs !== 1'b0 || bus.host_dtack !== 1'b0) begin bad++; $display("FAIL hd_end got=%b%b exp=00", bus.res_cs, bus.host_dtack); end
        tick;
        total++; if (bus.host_dtack !== 1'b1) begin bad++; $display("FAIL hd_pulse got=%b exp=1", bus.host_dtack); end
        total++; if (bus.host_rdata !== 8'hC3) begin bad++; $display("FAIL hd_rdata got=%h exp=c3", bus.host_rdata); end
        tick;
        total++; if (bus.host_dtack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL hd_pulse_end got=%b%b exp=00", bus.host_dtack, busy); end
        tick;
        total++; if (bus.host_dtack !== 1'b0) begin bad++; $display("FAIL hd_stays_low got=%b exp=0", bus.host_dtack); end
    endtask

    initial begin
        RESET = 1'b1;
        bus.host_req = 1'b0; bus.host_read = 1'b0; bus.host_addr = 4'd0; bus.host_wdata = 8'h00;
        bus.loc_req = 1'b0; bus.loc_read = 1'b0; bus.loc_addr = 4'd0; bus.loc_wdata = 8'h00;
        test_reset;
        test_host_read;
        test_local_write;
        test_drop_before_grant;
        test_round_robin;
        test_hold_blocks_local;
        test_reset_mid_access;
        test_host_drop;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
